// File: rtl/neuro_writeback_unit_pkg.sv
// Shared definitions for the neuron write-back unit: default widths,
// FSM state encoding and the signed range of a stored neuron value.
package neuro_writeback_unit_pkg;

  localparam int DEF_ACC_W      = 16;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_ADDR_W     = 8;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_SHIFT      = 4;

  // Signed range of a neuron value held in RAM.
  localparam int DATA_MAX = 127;
  localparam int DATA_MIN = -128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/neuro_writeback_unit_if.sv
// Bus bundle for the write-back unit: the MAC result stream (valid/ready)
// and the neuron-RAM write port (grant/strobe/address/data).
// master = MAC side + RAM arbiter, slave = write-back unit.
interface neuro_writeback_unit_if
  import neuro_writeback_unit_pkg::*;
#(
  parameter int ACC_W  = DEF_ACC_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) ();

  logic                     acc_valid;
  logic signed [ACC_W-1:0]  acc_data;
  logic                     acc_ready;

  logic                     wr_grant;
  logic                     wr_en;
  logic        [ADDR_W-1:0] wr_addr;
  logic signed [DATA_W-1:0] wr_data;

  modport master (
    output acc_valid, acc_data, wr_grant,
    input  acc_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  acc_valid, acc_data, wr_grant,
    output acc_ready, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/neuro_writeback_unit_wb_fifo.sv
// Small synchronous FIFO buffering requantized results between the MAC
// stream and the RAM write port. Pointers carry one extra wrap bit so that
// full and empty are distinguishable. The caller never pushes when full or
// pops when empty. Storage is not reset; only the pointers are.
module wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop_data = mem[rd_ptr[PTR_W-1:0]];

  // Advance read/write pointers; reset empties the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  // Store pushed data at the write slot.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/neuro_writeback_unit.sv
// Neuron write-back unit: accepts signed MAC results, requantizes each to a
// signed neuron value (arithmetic shift then saturation), buffers them and
// writes them to the neuron RAM at consecutive addresses from a per-layer
// base, then pulses layer_done.
// Optional build macro RELU_EN: negative requantized values are written as 0
// and the negative clamp no longer raises sat_flag.
module neuro_writeback_unit
  import neuro_writeback_unit_pkg::*;
#(
  parameter int ACC_W      = DEF_ACC_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int SHIFT      = DEF_SHIFT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   layer_start,
  input  logic [ADDR_W-1:0]      write_base,
  input  logic [ADDR_W-1:0]      neuron_count,
  neuro_writeback_unit_if.slave  bus,
  output logic                   busy,
  output logic                   layer_done,
  output logic                   sat_flag
);

  typedef struct packed {
    logic              sat;
    logic [DATA_W-1:0] val;
  } rq_t;

  localparam logic signed [ACC_W-1:0] Q_MAX = ACC_W'(DATA_MAX);
  localparam logic signed [ACC_W-1:0] Q_MIN = ACC_W'(DATA_MIN);

  // Shift the accumulator down to neuron scale and clamp to the stored range.
  function automatic rq_t requant(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] q;
    rq_t r;
    q     = acc >>> SHIFT;
    r.sat = 1'b0;
    r.val = q[DATA_W-1:0];
    if (q > Q_MAX) begin
      r.val = DATA_W'(DATA_MAX);
      r.sat = 1'b1;
    end else if (q < Q_MIN) begin
      r.val = DATA_W'(DATA_MIN);
`ifdef RELU_EN
      r.sat = 1'b0;
`else
      r.sat = 1'b1;
`endif
    end
`ifdef RELU_EN
    // ReLU after saturation: anything negative becomes zero.
    if (r.val[DATA_W-1]) r.val = '0;
`endif
    return r;
  endfunction

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] count_q;
  logic [ADDR_W-1:0] accepted;
  logic [ADDR_W-1:0] written;

  logic              acc_ready_c;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] head;
  rq_t               rq;
  logic              start_ok;

  assign rq          = requant(bus.acc_data);
  assign start_ok    = (state == IDLE) && layer_start;

  // Ready only depends on state and occupancy at the start of the cycle.
  assign acc_ready_c = (state == RUN) && !fifo_full && (accepted < count_q);
  assign push        = bus.acc_valid && acc_ready_c;
  assign pop         = !fifo_empty && bus.wr_grant;

  assign bus.acc_ready = acc_ready_c;
  assign bus.wr_en     = pop;
  assign bus.wr_addr   = base_q + written;
  assign bus.wr_data   = fifo_empty ? '0 : head;
  assign busy          = (state != IDLE);

  wb_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .push      (push),
    .push_data (rq.val),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic and the layer_done pulse.
  always_comb begin
    state_nx   = state;
    layer_done = 1'b0;
    case (state)
      IDLE: begin
        if (layer_start) state_nx = (neuron_count == '0) ? DONE : RUN;
      end
      RUN: begin
        if (push && ((accepted + ADDR_W'(1)) == count_q)) state_nx = DRAIN;
      end
      DRAIN: begin
        if (fifo_empty && (written == count_q)) state_nx = DONE;
      end
      DONE: begin
        layer_done = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Per-layer context: base/count latch, progress counters, sticky saturation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q   <= '0;
      count_q  <= '0;
      accepted <= '0;
      written  <= '0;
      sat_flag <= 1'b0;
    end else if (start_ok) begin
      base_q   <= write_base;
      count_q  <= neuron_count;
      accepted <= '0;
      written  <= '0;
      sat_flag <= 1'b0;
    end else begin
      if (push) begin
        accepted <= accepted + ADDR_W'(1);
        if (rq.sat) sat_flag <= 1'b1;
      end
      if (pop) written <= written + ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_neuro_writeback_unit.sv
// Testbench for neuro_writeback_unit: requantization vector table, hand
// sequences for backpressure, wrap, zero count, reset and ignored start,
// and randomized layers checked against an arithmetic reference model.
module tb_neuro_writeback_unit;

  logic       clk;
  logic       reset;
  logic       layer_start;
  logic [7:0] write_base;
  logic [7:0] neuron_count;
  logic       busy;
  logic       layer_done;
  logic       sat_flag;

  neuro_writeback_unit_if #(.ACC_W(16), .DATA_W(8), .ADDR_W(8)) bus ();

  neuro_writeback_unit dut (
    .clk          (clk),
    .reset        (reset),
    .layer_start  (layer_start),
    .write_base   (write_base),
    .neuron_count (neuron_count),
    .bus          (bus),
    .busy         (busy),
    .layer_done   (layer_done),
    .sat_flag     (sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    logic [15:0] acc;
    logic [7:0]  exp_data;
    logic        exp_sat;
  } vec_t;

  wr_t         wq[$];
  logic [15:0] res_q[$];
  vec_t        tbl[10];

  int cycle       = 0;
  int done_cnt    = 0;
  int done_cyc    = 0;
  int last_wr_cyc = 0;
  int n_chk       = 0;
  int n_fail      = 0;
  int idx         = 0;
  int cur_n       = 0;
  int start_done  = 0;

  always @(posedge clk) cycle <= cycle + 1;

  // Observe the RAM write port and layer_done away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.wr_en) begin
        wq.push_back('{bus.wr_addr, bus.wr_data});
        last_wr_cyc <= cycle;
      end
      if (layer_done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cycle;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: floor division by 16, clamp to [-128,127], optional ReLU.
  function automatic void model_rq(input logic [15:0] raw, output logic [7:0] d, output bit sat);
    int v;
    int q;
    v   = int'($signed(raw));
    if (v >= 0) q = v / 16;
    else        q = -((-v + 15) / 16);
    sat = 1'b0;
    if (q > 127) begin
      q   = 127;
      sat = 1'b1;
    end else if (q < -128) begin
      q   = -128;
`ifndef RELU_EN
      sat = 1'b1;
`endif
    end
`ifdef RELU_EN
    if (q < 0) q = 0;
`endif
    d = q[7:0];
  endfunction

  task automatic begin_layer(input logic [7:0] base, input int n);
    wq.delete();
    idx          = 0;
    cur_n        = n;
    start_done   = done_cnt;
    write_base   = base;
    neuron_count = 8'(n);
    layer_start  = 1'b1;
    @(posedge clk); #1;
    layer_start  = 1'b0;
  endtask

  task automatic step(input bit v, input bit g);
    bus.acc_valid = v && (idx < cur_n);
    bus.acc_data  = (idx < cur_n) ? res_q[idx] : 16'h0;
    bus.wr_grant  = g;
    @(negedge clk);
    if (bus.acc_valid && bus.acc_ready) idx++;
    @(posedge clk); #1;
  endtask

  task automatic run_to_done(input int vpct, input int gpct, input int glitch_at);
    int cyc;
    cyc = 0;
    while (((idx < cur_n) || (done_cnt == start_done)) && (cyc < 400)) begin
      if (cyc == glitch_at) begin
        layer_start  = 1'b1;
        write_base   = write_base + 8'h40;
        neuron_count = 8'd1;
      end
      step($urandom_range(1, 100) <= vpct, $urandom_range(1, 100) <= gpct);
      layer_start = 1'b0;
      cyc++;
    end
    bus.acc_valid = 1'b0;
    bus.wr_grant  = 1'b0;
  endtask

  task automatic check_layer(input logic [7:0] base, input string tag);
    logic [7:0] d;
    bit         s;
    bit         sat_any;
    repeat (2) begin @(posedge clk); #1; end
    chk({tag, " layer_done once"}, done_cnt - start_done, 1);
    chk({tag, " write count"}, wq.size(), cur_n);
    sat_any = 1'b0;
    for (int i = 0; i < cur_n; i++) begin
      model_rq(res_q[i], d, s);
      sat_any |= s;
      if (i < wq.size()) chk({tag, " write addr/data"}, {wq[i].addr, wq[i].data}, {8'(base + i), d});
    end
    chk({tag, " sat_flag"}, sat_flag, sat_any);
    if (wq.size() > 0) chk({tag, " done after last write"}, done_cyc > last_wr_cyc, 1);
  endtask

  initial begin
    reset         = 1'b1;
    layer_start   = 1'b0;
    write_base    = 8'h0;
    neuron_count  = 8'h0;
    bus.acc_valid = 1'b0;
    bus.acc_data  = 16'h0;
    bus.wr_grant  = 1'b0;

    // Requantization table: {acc, expected written byte, expected sat_flag}.
    tbl[0] = '{16'h0100, 8'h10, 1'b0};
    tbl[1] = '{16'h07F0, 8'h7F, 1'b0};
    tbl[2] = '{16'h0800, 8'h7F, 1'b1};
    tbl[3] = '{16'h7FFF, 8'h7F, 1'b1};
    tbl[4] = '{16'h000F, 8'h00, 1'b0};
`ifdef RELU_EN
    tbl[5] = '{16'hF800, 8'h00, 1'b0};
    tbl[6] = '{16'hF7F0, 8'h00, 1'b0};
    tbl[7] = '{16'hFFFF, 8'h00, 1'b0};
    tbl[8] = '{16'h8000, 8'h00, 1'b0};
    tbl[9] = '{16'hFFF1, 8'h00, 1'b0};
`else
    tbl[5] = '{16'hF800, 8'h80, 1'b0};
    tbl[6] = '{16'hF7F0, 8'h80, 1'b1};
    tbl[7] = '{16'hFFFF, 8'hFF, 1'b0};
    tbl[8] = '{16'h8000, 8'h80, 1'b1};
    tbl[9] = '{16'hFFF1, 8'hFF, 1'b0};
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("reset acc_ready", bus.acc_ready, 0);
    chk("reset wr_en", bus.wr_en, 0);
    chk("reset wr_addr", bus.wr_addr, 0);
    chk("reset wr_data", bus.wr_data, 0);
    chk("reset busy", busy, 0);
    chk("reset layer_done", layer_done, 0);
    chk("reset sat_flag", sat_flag, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic layer.
    res_q = '{16'h0100, 16'h0200, 16'hFFF0};
    begin_layer(8'h10, 3);
    run_to_done(100, 100, -1);
    check_layer(8'h10, "basic");
`ifdef RELU_EN
    if (wq.size() == 3) chk("basic third write", {wq[2].addr, wq[2].data}, 16'h1200);
`else
    if (wq.size() == 3) chk("basic third write", {wq[2].addr, wq[2].data}, 16'h12FF);
`endif

    // Saturation at both ends.
    res_q = '{16'h7FFF, 16'h8000};
    begin_layer(8'h20, 2);
    run_to_done(100, 100, -1);
    check_layer(8'h20, "sat");
    chk("sat sticky", sat_flag, 1);

    // Table-driven single-result layers.
    for (int i = 0; i < 10; i++) begin
      res_q = '{tbl[i].acc};
      begin_layer(8'(8'h80 + i), 1);
      run_to_done(100, 100, -1);
      check_layer(8'(8'h80 + i), "tbl");
      chk("tbl data", (wq.size() > 0) ? {24'h0, wq[0].data} : 32'hDEAD, tbl[i].exp_data);
      chk("tbl sat_flag", sat_flag, tbl[i].exp_sat);
    end

    // Backpressure: RAM withheld until the buffer fills.
    res_q.delete();
    for (int i = 0; i < 6; i++) res_q.push_back(16'(16'h0100 * (i + 1)));
    begin_layer(8'h30, 6);
    repeat (10) step(1'b1, 1'b0);
    chk("bp accepted", idx, 4);
    chk("bp acc_ready low", bus.acc_ready, 0);
    chk("bp no writes", wq.size(), 0);
    chk("bp busy", busy, 1);
    run_to_done(100, 100, -1);
    check_layer(8'h30, "bp");

    // Address wrap.
    res_q = '{16'h0010, 16'h0020, 16'h0030};
    begin_layer(8'hFE, 3);
    run_to_done(100, 100, -1);
    check_layer(8'hFE, "wrap");
    if (wq.size() == 3) chk("wrap last addr", wq[2].addr, 8'h00);

    // Zero-count layer.
    begin_layer(8'h44, 0);
    @(negedge clk);
    chk("zero layer_done", layer_done, 1);
    chk("zero wr_en", bus.wr_en, 0);
    @(negedge clk);
    chk("zero layer_done cleared", layer_done, 0);
    chk("zero busy", busy, 0);
    chk("zero done once", done_cnt - start_done, 1);
    chk("zero no writes", wq.size(), 0);
    @(posedge clk); #1;

    // Ignored start during RUN.
    res_q = '{16'h0110, 16'h0220, 16'h0330, 16'h0440, 16'h0550};
    begin_layer(8'h20, 5);
    run_to_done(100, 100, 1);
    check_layer(8'h20, "ignored start");

    // Asynchronous reset mid-layer.
    res_q = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500};
    begin_layer(8'h50, 5);
    for (int k = 0; (k < 20) && (idx < 2); k++) step(1'b1, 1'b0);
    chk("rst accepted two", idx, 2);
    bus.acc_valid = 1'b0;
    bus.wr_grant  = 1'b1;
    #1;
    chk("rst pre wr_en", bus.wr_en, 1);
    reset = 1'b1;
    #1;
    chk("rst wr_en", bus.wr_en, 0);
    chk("rst acc_ready", bus.acc_ready, 0);
    chk("rst busy", busy, 0);
    chk("rst wr_addr", bus.wr_addr, 0);
    chk("rst wr_data", bus.wr_data, 0);
    chk("rst sat_flag", sat_flag, 0);
    repeat (2) @(posedge clk);
    #1;
    reset        = 1'b0;
    bus.wr_grant = 1'b0;
    @(posedge clk); #1;
    chk("rst no writes", wq.size(), 0);
    chk("rst no layer_done", done_cnt - start_done, 0);
    res_q = '{16'h0700, 16'hFF00, 16'h0080, 16'h1234};
    begin_layer(8'h60, 4);
    run_to_done(100, 100, -1);
    check_layer(8'h60, "after rst");

    // Randomized layers against the reference model.
    for (int r = 0; r < 12; r++) begin
      logic [7:0] b;
      int         n;
      b = 8'($urandom);
      n = $urandom_range(1, 12);
      res_q.delete();
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 1) == 0) res_q.push_back(16'($urandom));
        else                           res_q.push_back(16'(int'($urandom_range(0, 4600)) - 2300));
      end
      begin_layer(b, n);
      run_to_done($urandom_range(50, 100), $urandom_range(30, 100), -1);
      check_layer(b, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
